flop_bank: RTL and testbench

- Bundles three WIDTH-bit banks of single-clock storage elements: D flip-flops, JK flip-flops and clocked SR cells.
- Each bank has true and complement outputs.
- Serves as the common storage primitive for counters and pulse-generation logic.
- All state updates on the rising edge of clk; no internal combinational feedback latches.

---
 rtl/flop_bank_pkg.sv | 14 +
 rtl/flop_bank_jk.sv | 41 ++++
 rtl/flop_bank.sv | 96 +++++++++
 tb/tb_flop_bank.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/flop_bank_pkg.sv
// Shared types and constants for the flop_bank storage primitives.
// JK command encoding is {j,k}; reset state of every cell is Q=0.
package flop_bank_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_t;

  localparam logic RST_Q = 1'b0;

endpackage

// File: rtl/flop_bank_jk.sv
// jk_cell: 1-bit JK register, synchronous active-high reset, clock enable.
// Reset wins over enable and over the J/K command.
module jk_cell
  import flop_bank_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  logic    q_q;
  logic    q_d;
  jk_cmd_t cmd;

  assign cmd = jk_cmd_t'({j, k});

  always_comb begin
    q_d = q_q;
    unique case (cmd)
      JK_HOLD: q_d = q_q;
      JK_RST:  q_d = 1'b0;
      JK_SET:  q_d = 1'b1;
      JK_TGL:  q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_Q;
    end else if (en) begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/flop_bank.sv
// flop_bank: D, JK and SR banks built from jk_cell, true/complement outputs.
// Optional per-bank enables under `FLOP_BANK_ENABLE_EN.
module flop_bank
  import flop_bank_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FLOP_BANK_ENABLE_EN
  input  logic             en_d,
  input  logic             en_jk,
  input  logic             en_sr,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] d_q,
  output logic [WIDTH-1:0] d_qn,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] jk_q,
  output logic [WIDTH-1:0] jk_qn,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] sr_q,
  output logic [WIDTH-1:0] sr_qn,
  output logic [WIDTH-1:0] sr_invalid
);

  logic ena_d;
  logic ena_jk;
  logic ena_sr;

`ifdef FLOP_BANK_ENABLE_EN
  assign ena_d  = en_d;
  assign ena_jk = en_jk;
  assign ena_sr = en_sr;
`else
  assign ena_d  = 1'b1;
  assign ena_jk = 1'b1;
  assign ena_sr = 1'b1;
`endif

  logic [WIDTH-1:0] inv_q;
  logic [WIDTH-1:0] inv_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_cell u_d (
      .clk (clk),
      .rst (rst),
      .en  (ena_d),
      .j   (d[i]),
      .k   (~d[i]),
      .q   (d_q[i])
    );

    jk_cell u_jk (
      .clk (clk),
      .rst (rst),
      .en  (ena_jk),
      .j   (j[i]),
      .k   (k[i]),
      .q   (jk_q[i])
    );

    // S=R=1 resolves as a reset; the flag records it.
    jk_cell u_sr (
      .clk (clk),
      .rst (rst),
      .en  (ena_sr),
      .j   (s[i] & ~r[i]),
      .k   (r[i]),
      .q   (sr_q[i])
    );
  end

  always_comb begin
    inv_d = inv_q;
    if (ena_sr) begin
      inv_d = s & r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q <= '0;
    end else begin
      inv_q <= inv_d;
    end
  end

  assign d_qn       = ~d_q;
  assign jk_qn      = ~jk_q;
  assign sr_qn      = ~sr_q & ~inv_q;
  assign sr_invalid = inv_q;

endmodule

// File: tb/tb_flop_bank.sv
// Directed self-checking bench for flop_bank (WIDTH=4).
// Enable checks are built only with FLOP_BANK_ENABLE_EN.
module tb_flop_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
`ifdef FLOP_BANK_ENABLE_EN
  logic       en_d = 1'b1;
  logic       en_jk = 1'b1;
  logic       en_sr = 1'b1;
`endif
  logic [3:0] d = '0;
  logic [3:0] j = '0;
  logic [3:0] k = '0;
  logic [3:0] s = '0;
  logic [3:0] r = '0;
  logic [3:0] d_q, d_qn, jk_q, jk_qn;
  logic [3:0] sr_q, sr_qn, sr_invalid;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  flop_bank #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef FLOP_BANK_ENABLE_EN
    .en_d       (en_d),
    .en_jk      (en_jk),
    .en_sr      (en_sr),
`endif
    .d          (d),
    .d_q        (d_q),
    .d_qn       (d_qn),
    .j          (j),
    .k          (k),
    .jk_q       (jk_q),
    .jk_qn      (jk_qn),
    .s          (s),
    .r          (r),
    .sr_q       (sr_q),
    .sr_qn      (sr_qn),
    .sr_invalid (sr_invalid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_d(input string tag, input logic [3:0] e);
    chk({tag, ".d_q"}, d_q, e);
    chk({tag, ".d_qn"}, d_qn, ~e);
  endtask

  task automatic chk_jk(input string tag, input logic [3:0] e);
    chk({tag, ".jk_q"}, jk_q, e);
    chk({tag, ".jk_qn"}, jk_qn, ~e);
  endtask

  task automatic chk_sr(input string tag, input logic [3:0] q,
                        input logic [3:0] qn, input logic [3:0] inv);
    chk({tag, ".sr_q"}, sr_q, q);
    chk({tag, ".sr_qn"}, sr_qn, qn);
    chk({tag, ".sr_inv"}, sr_invalid, inv);
  endtask

  initial begin
    // reset with all inputs high
    rst = 1'b1;
    d = 4'hF; j = 4'hF; k = 4'hF;
    s = 4'hF; r = 4'hF;
    tick();
    tick();
    chk_d("rst", 4'h0);
    chk_jk("rst", 4'h0);
    chk_sr("rst", 4'h0, 4'hF, 4'h0);

    // release: nothing moves before the edge
    rst = 1'b0;
    d = 4'hF; j = 4'hF; k = 4'h0; s = 4'hF; r = 4'h0;
    #2;
    chk_d("rel_pre", 4'h0);
    chk_jk("rel_pre", 4'h0);
    chk_sr("rel_pre", 4'h0, 4'hF, 4'h0);
    d = 4'h0; j = 4'h0; k = 4'h0; s = 4'h0; r = 4'h0;
    tick();
    chk_d("rel_post", 4'h0);
    chk_jk("rel_post", 4'h0);
    chk_sr("rel_post", 4'h0, 4'hF, 4'h0);

    // D bank
    d = 4'h0; tick(); chk_d("d0", 4'h0);
    d = 4'hA; tick(); chk_d("d1", 4'hA);
    d = 4'hF; tick(); chk_d("d2", 4'hF);
    d = 4'h5; tick(); chk_d("d3", 4'h5);
    d = 4'h3; tick(); chk_d("d4", 4'h3);
    d = 4'hC; #2; d = 4'h6;
    tick(); chk_d("d_glitch", 4'h6);

    // JK bank, all bits
    j = 4'h0; k = 4'h0; tick(); chk_jk("jk00", 4'h0);
    j = 4'h0; k = 4'hF; tick(); chk_jk("jk01", 4'h0);
    j = 4'hF; k = 4'h0; tick(); chk_jk("jk10", 4'hF);
    j = 4'hF; k = 4'hF; tick(); chk_jk("jk11a", 4'h0);
    j = 4'hF; k = 4'hF; tick(); chk_jk("jk11b", 4'hF);
    j = 4'hF; k = 4'h0; tick(); chk_jk("jk10b", 4'hF);
    j = 4'h0; k = 4'h0; tick(); chk_jk("jk00b", 4'hF);
    j = 4'h0; k = 4'hF; tick(); chk_jk("jk01b", 4'h0);
    // per-bit mix: b3 tgl, b2 set, b1 rst, b0 hold
    j = 4'b1100; k = 4'b1010;
    tick(); chk_jk("jk_mix1", 4'hC);
    tick(); chk_jk("jk_mix2", 4'h4);

    // SR bank
    s = 4'hF; r = 4'hF; tick();
    chk_sr("sr11", 4'h0, 4'h0, 4'hF);
    s = 4'h0; r = 4'h0; tick();
    chk_sr("sr00", 4'h0, 4'hF, 4'h0);
    s = 4'hF; r = 4'h0; tick();
    chk_sr("sr10", 4'hF, 4'h0, 4'h0);
    s = 4'h0; r = 4'hF; tick();
    chk_sr("sr01", 4'h0, 4'hF, 4'h0);
    s = 4'hF; r = 4'hF; tick();
    chk_sr("sr11b", 4'h0, 4'h0, 4'hF);
    // b3 set, b2 rst, b1 invalid, b0 hold
    s = 4'b1010; r = 4'b0110; tick();
    chk_sr("sr_mix", 4'h8, 4'h5, 4'h2);

    // mid-operation reset with toggle/set requested
    d = 4'hF; j = 4'hF; k = 4'hF;
    s = 4'hF; r = 4'h0;
    rst = 1'b1; tick();
    chk_d("mrst", 4'h0);
    chk_jk("mrst", 4'h0);
    chk_sr("mrst", 4'h0, 4'hF, 4'h0);
    rst = 1'b0; tick();
    chk_d("mrst_run", 4'hF);
    chk_jk("mrst_run", 4'hF);
    chk_sr("mrst_run", 4'hF, 4'h0, 4'h0);
    tick();
    chk_jk("mrst_tgl", 4'h0);

`ifdef FLOP_BANK_ENABLE_EN
    // jk_q=0, d_q=F, sr_q=F here
    en_jk = 1'b0; j = 4'hF; k = 4'hF;
    tick(); chk_jk("en_jk1", 4'h0);
    tick(); chk_jk("en_jk2", 4'h0);
    tick(); chk_jk("en_jk3", 4'h0);
    en_d = 1'b0;
    d = 4'h0; tick(); chk_d("en_d1", 4'hF);
    d = 4'h9; tick(); chk_d("en_d2", 4'hF);
    en_sr = 1'b0; s = 4'hF; r = 4'hF;
    tick(); chk_sr("en_sr", 4'hF, 4'h0, 4'h0);
    rst = 1'b1; tick();
    chk_d("en_rst", 4'h0);
    chk_jk("en_rst", 4'h0);
    chk_sr("en_rst", 4'h0, 4'hF, 4'h0);
    rst = 1'b0;
    en_d = 1'b1; en_jk = 1'b1; en_sr = 1'b1;
    d = 4'h7; tick(); chk_d("en_back", 4'h7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
